sram_sp_arbiter: RTL and testbench

//  Shares one single-port SRAM macro (128x32, CEB/WEB active-low, 1-cycle read) between two requesters.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/sram_sp_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_sp_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Read latency follows SRAM_ARB_OUT_REG_EN (output register on the macro read data).
package sram_arb_pkg;
    localparam int SRAM_ARB_DATA_W = 32;
    localparam int SRAM_ARB_DEPTH  = 128;
    localparam int SRAM_ARB_ADDR_W = $clog2(SRAM_ARB_DEPTH);

`ifdef SRAM_ARB_OUT_REG_EN
    localparam int SRAM_ARB_RD_LAT = 2;
`else
    localparam int SRAM_ARB_RD_LAT = 1;
`endif

    typedef enum logic {INIT, RUN} sram_arb_state_e;

    typedef struct packed {
        logic                       we;
        logic [SRAM_ARB_ADDR_W-1:0] addr;
        logic [SRAM_ARB_DATA_W-1:0] wdata;
    } sram_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grant is one-hot or zero, ptr names the favoured requester.
// Latency 0 (purely combinational); en=0 forces no grant and holds the pointer.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] grant,
    output logic       ptr_nxt
);
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
        // The loser of this cycle is favoured next time.
        ptr_nxt = ptr;
        if (grant[0])
            ptr_nxt = 1'b1;
        else if (grant[1])
            ptr_nxt = 1'b0;
    end
endmodule

// File: rtl/sram_sp_arbiter.sv
// Round-robin share of one single-port SRAM between two requesters, zero-filling the array after reset/clear.
// Grant and macro drive in the request cycle; read data 1 cycle later (2 with SRAM_ARB_OUT_REG_EN).
// req_ready held low during initialisation and on clear; responses cannot be back-pressured.
module sram_sp_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int DATA_W = SRAM_ARB_DATA_W,
    parameter  int DEPTH  = SRAM_ARB_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    output logic                   init_done,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   sram_ceb,
    output logic                   sram_web,
    output logic [ADDR_W-1:0]      sram_a,
    output logic [DATA_W-1:0]      sram_d,
    input  logic [DATA_W-1:0]      sram_q
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sram_arb_state_e                    state;
    logic [ADDR_W-1:0]                  init_cnt;
    logic [ADDR_W-1:0]                  a_q;
    logic [DATA_W-1:0]                  d_q;
    logic                               rr_ptr;
    logic                               ptr_nxt;
    logic [1:0]                         grant;
    logic                               gidx;
    logic [1:0]                         rd_grant;
    sram_req_t                          sel;
    logic [SRAM_ARB_RD_LAT-1:0][1:0]    rd_pipe;

    rr_arb2 u_arb (
        .valid   (req_valid),
        .ptr     (rr_ptr),
        .en      (state == RUN && !clear),
        .grant   (grant),
        .ptr_nxt (ptr_nxt)
    );

    assign req_ready = grant;
    assign gidx      = grant[1];
    assign rd_grant  = grant & ~req_we;

    always_comb begin
        sel      = '{we: req_we[gidx], addr: req_addr[gidx], wdata: req_wdata[gidx]};
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = a_q;
        sram_d   = d_q;
        // Reset gate keeps the macro idle while reset is held, even though state reads INIT.
        if (!reset) begin
            if (state == INIT) begin
                sram_ceb = 1'b0;
                sram_web = 1'b0;
                sram_a   = init_cnt;
                sram_d   = '0;
            end else if (grant != 2'b00) begin
                sram_ceb = 1'b0;
                sram_web = ~sel.we;
                sram_a   = sel.addr;
                sram_d   = sel.wdata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            rr_ptr    <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
        end else begin
            a_q    <= sram_a;
            d_q    <= sram_d;
            rr_ptr <= ptr_nxt;
            case (state)
                INIT: begin
                    if (clear) begin
                        init_cnt <= '0;
                    end else if (init_cnt == LAST_ADDR) begin
                        init_cnt  <= '0;
                        state     <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state     <= INIT;
                        init_cnt  <= '0;
                        init_done <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Response pipe is not flushed by clear: reads accepted before it still answer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_grant;
            for (int i = 1; i < SRAM_ARB_RD_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign resp_valid = rd_pipe[SRAM_ARB_RD_LAT-1];

`ifdef SRAM_ARB_OUT_REG_EN
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q_reg <= '0;
        else
            q_reg <= sram_q;
    end

    assign resp_rdata = q_reg;
`else
    assign resp_rdata = sram_q;
`endif
endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Randomised and directed bench for sram_sp_arbiter against a transaction-level model and a behavioural macro.
module tb_sram_sp_arbiter;
    localparam int DEPTH = 128;
`ifdef SRAM_ARB_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            clear;
    logic            init_done;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [1:0][6:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]      resp_valid;
    logic [31:0]     resp_rdata;
    logic            sram_ceb;
    logic            sram_web;
    logic [6:0]      sram_a;
    logic [31:0]     sram_d;
    logic [31:0]     sram_q;

    sram_sp_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .init_done  (init_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .sram_ceb   (sram_ceb),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    always #5 clock = ~clock;

    // Behavioural macro: garbage at power-up, 1-cycle read.
    logic [31:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        sram_q = $urandom;
    end
    always @(posedge clock) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    // Macro write log for the initialisation sweep.
    logic [38:0] wlog [$];
    bit          log_en = 1'b0;
    always @(negedge clock) begin
        if (log_en && !sram_ceb && !sram_web) wlog.push_back({sram_a, sram_d});
    end

    // Reference model state.
    typedef struct {
        int          due;
        logic [1:0]  who;
        logic [31:0] data;
    } exp_t;

    logic [31:0] ref_mem [DEPTH];
    exp_t        rq [$];
    int          init_left;
    int          model_ptr;
    int          cyc_n = 0;
    logic [31:0] last_rd0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    endtask

    task automatic model_reset();
        rq.delete();
        init_left = DEPTH;
        model_ptr = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Called at posedge+1; asserts reset away from any edge and checks the outputs at once.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_ceb", sram_ceb, 1);
        check_eq("rst_web", sram_web, 1);
        check_eq("rst_a", sram_a, 0);
        check_eq("rst_d", sram_d, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, check against the model at negedge, advance the model.
    task automatic cyc(input logic clr, input logic [1:0] v, input logic [1:0] we,
                       input logic [6:0] a0, input logic [6:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        logic        run;
        logic [1:0]  g;
        int          w;
        logic [1:0]  ev;
        logic [31:0] ed;
        logic [6:0]  ga;
        exp_t        e;
        clear        = clr;
        req_valid    = v;
        req_we       = we;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
        @(negedge clock);
        run = (init_left == 0);
        g   = 2'b00;
        w   = 0;
        if (run && !clr) begin
            if (v == 2'b11) w = model_ptr;
            else            w = v[1] ? 1 : 0;
            if (v != 2'b00) g = (w == 1) ? 2'b10 : 2'b01;
        end
        ga = (w == 1) ? a1 : a0;
        check_eq("init_done", init_done, run);
        check_eq("req_ready", req_ready, g);
        check_eq("sram_ceb", sram_ceb, run ? (g == 2'b00) : 1'b0);
        check_eq("sram_web", sram_web, run ? ((g == 2'b00) ? 1'b1 : !we[w]) : 1'b0);
        if (!run) check_eq("init_d", sram_d, 0);
        if (g != 2'b00) check_eq("sram_a", sram_a, ga);
        ev = 2'b00;
        ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc_n) begin
            e  = rq.pop_front();
            ev = e.who;
            ed = e.data;
        end
        check_eq("resp_valid", resp_valid, ev);
        if (ev != 2'b00) check_eq("resp_rdata", resp_rdata, ed);
        if (resp_valid[0]) last_rd0 = resp_rdata;
        if (g != 2'b00) begin
            if (we[w]) ref_mem[ga] = (w == 1) ? d1 : d0;
            else       rq.push_back('{due: cyc_n + LAT, who: g, data: ref_mem[ga]});
            model_ptr = (w == 0) ? 1 : 0;
        end
        if (!run) init_left--;
        if (clr) begin
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end
        @(posedge clock);
        #1 cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);
    endtask

    initial begin
        int errs;
        reset = 1'b1;
        clear = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        model_reset();

        // 1: reset, zero-fill sweep
        do_reset();
        wlog.delete();
        log_en = 1'b1;
        idle(DEPTH);
        log_en = 1'b0;
        check_eq("init_wr_count", wlog.size(), DEPTH);
        errs = 0;
        for (int i = 0; i < wlog.size() && i < DEPTH; i++)
            if (wlog[i] !== {7'(i), 32'd0}) errs++;
        check_eq("init_wr_order", errs, 0);

        // 2: single read of a zeroed word
        last_rd0 = 32'hFFFF_FFFF;
        cyc(1'b0, 2'b01, 2'b00, 7'd5, 7'd0, 32'd0, 32'd0);
        idle(LAT + 1);
        check_eq("rd5_data", last_rd0, 32'h0);

        // 3: alternating grants from ptr=0 and read-after-write across requesters
        cyc(1'b0, 2'b10, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);
        cyc(1'b0, 2'b11, 2'b10, 7'd3, 7'd9, 32'd0, 32'hDEAD_BEEF);
        cyc(1'b0, 2'b11, 2'b10, 7'd9, 7'd9, 32'd0, 32'hDEAD_BEEF);
        cyc(1'b0, 2'b11, 2'b00, 7'd9, 7'd4, 32'd0, 32'd0);
        cyc(1'b0, 2'b11, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);
        idle(LAT + 1);
        check_eq("raw_9", last_rd0, 32'hDEAD_BEEF);

        // 4: clear re-zeroes; read accepted just before clear still answers
        cyc(1'b0, 2'b01, 2'b01, 7'd127, 7'd0, 32'h1234_5678, 32'd0);
        cyc(1'b0, 2'b01, 2'b00, 7'd127, 7'd0, 32'd0, 32'd0);
        cyc(1'b1, 2'b11, 2'b00, 7'd1, 7'd2, 32'd0, 32'd0);
        check_eq("pre_clear_rd", last_rd0, 32'h1234_5678);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 2'b11, 2'b00, 7'd127, 7'd127, 32'd0, 32'd0);
        last_rd0 = 32'hFFFF_FFFF;
        cyc(1'b0, 2'b01, 2'b00, 7'd127, 7'd0, 32'd0, 32'd0);
        idle(LAT + 1);
        check_eq("rd127_after_clear", last_rd0, 32'h0);

        // 5: async reset mid-INIT, then mid-read
        cyc(1'b1, 2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0);
        idle(20);
        do_reset();
        idle(DEPTH + 2);
        cyc(1'b0, 2'b01, 2'b01, 7'd7, 7'd0, 32'hA5A5_0007, 32'd0);
        cyc(1'b0, 2'b10, 2'b00, 7'd0, 7'd7, 32'd0, 32'd0);
        do_reset();
        idle(DEPTH + 4);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            logic [6:0] ra0, ra1;
            ra0 = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
            cyc(($urandom_range(0, 99) == 0), 2'($urandom), 2'($urandom),
                ra0, ra1, $urandom, $urandom);
        end
        idle(DEPTH + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
